rob_commit_stage: RTL

Multi-lane in-order commit stage between the reorder buffer head and the architectural register file. Each cycle it examines up to COMMIT_WIDTH oldest ROB entries, retires the longest contiguous run of completed entries, and issues registered architectural writes with same-cycle WAW resolution and x0 suppression. Exceptions stop retirement at the faulting entry, raise a one-cycle pipeline flush, and hold commit until the ROB reports empty.

---
 rtl/commit_pkg.sv | 14 +
 rtl/commit_waw_filter.sv | 23 ++
 rtl/rob_commit_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/commit_pkg.sv
// Shared types and constants for the ROB commit stage.
package commit_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } commit_state_e;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_AREG_W = 5;
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/commit_waw_filter.sv
// Same-cycle WAW resolution: clears a lane's write request when a younger
// requesting lane targets the same destination.
module commit_waw_filter #(
    parameter int N      = 2,
    parameter int AREG_W = 5
) (
    input  logic [N-1:0]        req_i,
    input  logic [N*AREG_W-1:0] dest_i,
    output logic [N-1:0]        en_o
);

    always_comb begin
        en_o = req_i;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                if (req_i[j] && (dest_i[j*AREG_W +: AREG_W] == dest_i[i*AREG_W +: AREG_W])) begin
                    en_o[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/rob_commit_stage.sv
// In-order multi-lane commit stage between ROB head and architectural RF.
// Optional retired-instruction counter enabled by COMMIT_PERF_CNT_EN.
//
// state    | meaning
// ST_RUN   | normal retirement of the leading completed run
// ST_FLUSH | single-cycle flush pulse after a faulting pop
// ST_DRAIN | commit held until the ROB reports empty
module rob_commit_stage
    import commit_pkg::*;
#(
    parameter int COMMIT_WIDTH = 2,
    parameter int XLEN         = DEF_XLEN,
    parameter int AREG_W       = DEF_AREG_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [COMMIT_WIDTH-1:0]           head_valid,
    input  logic [COMMIT_WIDTH-1:0]           head_done,
    input  logic [COMMIT_WIDTH-1:0]           head_wr,
    input  logic [COMMIT_WIDTH-1:0]           head_exc,
    input  logic [COMMIT_WIDTH*AREG_W-1:0]    head_dest,
    input  logic [COMMIT_WIDTH*XLEN-1:0]      head_value,
    input  logic [COMMIT_WIDTH*XLEN-1:0]      head_pc,
    input  logic                              rob_empty,
    output logic [$clog2(COMMIT_WIDTH+1)-1:0] pop_count,
    output logic [COMMIT_WIDTH-1:0]           arch_wr_en,
    output logic [COMMIT_WIDTH*AREG_W-1:0]    arch_wr_addr,
    output logic [COMMIT_WIDTH*XLEN-1:0]      arch_wr_data,
    output logic                              flush,
    output logic [XLEN-1:0]                   flush_pc
`ifdef COMMIT_PERF_CNT_EN
    ,
    output logic [63:0]                       retired_count
`endif
);

    localparam int CNT_W  = $clog2(COMMIT_WIDTH + 1);
    localparam int LANE_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;

    commit_state_e state_q, state_d;

    logic [CNT_W-1:0]        run_len;
    logic                    fault_hit;
    logic [LANE_W-1:0]       fault_lane;
    logic                    in_run;
    logic                    is_run;
    logic                    fault;
    logic [CNT_W-1:0]        retire_cnt;
    logic [COMMIT_WIDTH-1:0] wr_req;
    logic [COMMIT_WIDTH-1:0] wr_mask;

    logic [COMMIT_WIDTH-1:0]        arch_wr_en_q;
    logic [COMMIT_WIDTH*AREG_W-1:0] arch_wr_addr_q;
    logic [COMMIT_WIDTH*XLEN-1:0]   arch_wr_data_q;
    logic                           flush_q;
    logic [XLEN-1:0]                flush_pc_q;

    // Leading run of clean completed entries; the first non-clean lane ends it.
    always_comb begin
        run_len    = '0;
        fault_hit  = 1'b0;
        fault_lane = '0;
        in_run     = 1'b1;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (in_run) begin
                if (head_valid[i] && head_done[i] && !head_exc[i]) begin
                    run_len = run_len + CNT_W'(1);
                end else begin
                    if (head_valid[i] && head_done[i]) begin
                        fault_hit  = 1'b1;
                        fault_lane = LANE_W'(i);
                    end
                    in_run = 1'b0;
                end
            end
        end
    end

    assign is_run     = (state_q == ST_RUN);
    assign fault      = is_run && fault_hit;
    assign retire_cnt = is_run ? run_len : '0;
    assign pop_count  = retire_cnt + CNT_W'(fault);

    always_comb begin
        wr_req = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            wr_req[i] = (CNT_W'(i) < retire_cnt) && head_wr[i]
                        && (head_dest[i*AREG_W +: AREG_W] != AREG_W'(REG_ZERO));
        end
    end

    commit_waw_filter #(
        .N      (COMMIT_WIDTH),
        .AREG_W (AREG_W)
    ) u_waw_filter (
        .req_i  (wr_req),
        .dest_i (head_dest),
        .en_o   (wr_mask)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (fault_hit) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_DRAIN;
            ST_DRAIN: if (rob_empty) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arch_wr_en_q   <= '0;
            arch_wr_addr_q <= '0;
            arch_wr_data_q <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else begin
            arch_wr_en_q   <= wr_mask;
            arch_wr_addr_q <= head_dest;
            arch_wr_data_q <= head_value;
            flush_q        <= fault;
            if (fault) begin
                flush_pc_q <= head_pc[fault_lane*XLEN +: XLEN];
            end
        end
    end

    assign arch_wr_en   = arch_wr_en_q;
    assign arch_wr_addr = arch_wr_addr_q;
    assign arch_wr_data = arch_wr_data_q;
    assign flush        = flush_q;
    assign flush_pc     = flush_pc_q;

`ifdef COMMIT_PERF_CNT_EN
    logic [63:0] retired_q;

    // Faulting entries are popped but not counted as retired.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_q + 64'(retire_cnt);
        end
    end

    assign retired_count = retired_q;
`endif

endmodule
